adder_result_fifo: RTL and testbench

- Downstream stage of the 4-bit adder. Captures each enabled {Overflow, Sum} result into a small FIFO and presents results to the next consumer over a valid/ready handshake.
- Keeps a saturating count of overflowed results for status/debug.
- Decouples the adder's per-cycle output from a consumer that may stall.

---
 rtl/adder_result_fifo.sv | 123 ++++++++++++
 tb/tb_adder_result_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// Result FIFO behind the 4-bit adder: buffers {Overflow, Sum} entries (first-word-fall-through),
// hands them out over valid/ready and keeps a saturating count of accepted overflow results.
module adder_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     In_Valid,
    input  logic [WIDTH-1:0]         Sum,
    input  logic                     Overflow,
    output logic                     In_Ready,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [WIDTH:0]           Out_Data,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic [CNT_W-1:0]         Ovf_Count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_ovf_count;

    logic             w_write;
    logic             w_read;
    logic             w_full;
    logic             w_empty;

    assign w_full   = (r_state == S_FULL);
    assign w_empty  = (r_state == S_EMPTY);

    // No pass-through: a full FIFO refuses input even if the head is read this cycle.
    assign w_write  = In_Valid & ~w_full;
    assign w_read   = Out_Ready & ~w_empty;

    assign In_Ready  = ~w_full;
    assign Out_Valid = ~w_empty;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Count     = r_count;
    assign Ovf_Count = r_ovf_count;
    assign Out_Data  = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge Clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {Overflow, Sum};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_EMPTY;
            r_count <= '0;
        end else begin
            if (w_write && !w_read) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_read && !w_write) begin
                r_count <= r_count - (AW+1)'(1);
            end

            case (r_state)
                S_EMPTY: begin
                    if (w_write) begin
                        r_state <= S_PARTIAL;
                    end
                end
                S_PARTIAL: begin
                    if (w_write && !w_read && r_count == LP_LAST) begin
                        r_state <= S_FULL;
                    end else if (w_read && !w_write && r_count == (AW+1)'(1)) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_read) begin
                        r_state <= S_PARTIAL;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ovf_count <= '0;
        end else if (w_write && Overflow && r_ovf_count != '1) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo: directed scenarios plus randomized traffic against a queue model;
// a second instance with a 2-bit overflow counter exercises saturation.
module tb_adder_result_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] sum = '0;
    logic       overflow = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, full, empty;
    logic [4:0] out_data;
    logic [2:0] count;
    logic [7:0] ovf_count;

    logic       s_in_ready, s_out_valid, s_full, s_empty;
    logic [4:0] s_out_data;
    logic [2:0] s_count;
    logic [1:0] s_ovf_count;

    int checks = 0;
    int errors = 0;

    logic [4:0] q[$];
    int m_ovf = 0;
    int m_ovf2 = 0;

    always #5 clk = ~clk;

    adder_result_fifo #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .Clk(clk), .Reset(reset), .In_Valid(in_valid), .Sum(sum), .Overflow(overflow),
        .In_Ready(in_ready), .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Data(out_data),
        .Count(count), .Full(full), .Empty(empty), .Ovf_Count(ovf_count)
    );

    adder_result_fifo #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut_s (
        .Clk(clk), .Reset(reset), .In_Valid(in_valid), .Sum(sum), .Overflow(overflow),
        .In_Ready(s_in_ready), .Out_Valid(s_out_valid), .Out_Ready(out_ready), .Out_Data(s_out_data),
        .Count(s_count), .Full(s_full), .Empty(s_empty), .Ovf_Count(s_ovf_count)
    );

    // Advance one clock edge and apply the same event to the reference model.
    task automatic tick();
        bit w, r;
        logic [4:0] entry;
        w = in_valid && (q.size() < DEPTH);
        r = out_ready && (q.size() > 0);
        entry = {overflow, sum};
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovf = 0;
            m_ovf2 = 0;
        end else begin
            if (r) void'(q.pop_front());
            if (w) begin
                q.push_back(entry);
                if (entry[4]) begin
                    if (m_ovf < 255) m_ovf++;
                    if (m_ovf2 < 3) m_ovf2++;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        out_ready = 1'b0;
        overflow = 1'b0;
        sum = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf got=%0d exp=0", ovf_count); end
    endtask

    task automatic test_single_write();
        do_reset();
        in_valid = 1'b1; sum = 4'd4; overflow = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 5'b00100) begin errors++; $display("FAIL single_data got=%b exp=00100", out_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", empty); end
    endtask

    task automatic test_fill_and_drop();
        logic [3:0] vals [5];
        logic [4:0] exp_d;
        vals = '{4'd4, 4'd2, 4'd8, 4'd15, 4'd9};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; sum = vals[i]; overflow = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        // Drop while full with a simultaneous read: 9 must still be refused.
        in_valid = 1'b1; sum = 4'd9; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_drop_rd_count got=%0d exp=3", count); end
        for (int i = 1; i < 4; i++) begin
            exp_d = {1'b0, vals[i]};
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, out_data, exp_d); end
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
        tick();
        checks++; if (out_data !== 5'd0 || count !== 3'd0) begin
            errors++; $display("FAIL read_empty got data=%h count=%0d exp data=0 count=0", out_data, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_d;
        do_reset();
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1; sum = 4'(i); overflow = 1'b0;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sum = 4'(i + 3);
            exp_d = 5'(i + 1);
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, exp_d); end
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
            tick();
        end
        idle_inputs();
        checks++; if (out_data !== 5'd7) begin errors++; $display("FAIL b2b_tail got=%h exp=07", out_data); end
    endtask

    task automatic test_ovf_count();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            overflow = (i < 3);
            sum = (i < 3) ? 4'd8 : 4'd5;
            tick();
        end
        idle_inputs();
        checks++; if (ovf_count !== 8'd3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", ovf_count); end
        checks++; if (out_data !== 5'b11000) begin errors++; $display("FAIL ovf_head got=%b exp=11000", out_data); end
        // A dropped overflow write while full must not count.
        in_valid = 1'b1; overflow = 1'b1; sum = 4'd1;
        tick();
        idle_inputs();
        checks++; if (ovf_count !== 8'd3) begin errors++; $display("FAIL ovf_dropped got=%0d exp=3", ovf_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; overflow = 1'b1; sum = 4'(i);
            tick();
        end
        idle_inputs();
        checks++; if (s_ovf_count !== 2'd3) begin errors++; $display("FAIL sat_ovf2 got=%0d exp=3", s_ovf_count); end
        checks++; if (ovf_count !== 8'd5) begin errors++; $display("FAIL sat_ovf8 got=%0d exp=5", ovf_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; overflow = 1'b1; sum = 4'(i + 10);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_state got count=%0d empty=%b valid=%b exp 0/1/0", count, empty, out_valid);
        end
        checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL midrst_data got=%h exp=0", out_data); end
        checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL midrst_ovf got=%0d exp=0", ovf_count); end
        in_valid = 1'b1; sum = 4'd6; overflow = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== 5'd6) begin errors++; $display("FAIL midrst_first got=%h exp=06", out_data); end
    endtask

    task automatic test_random();
        logic [4:0] exp_d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) < ((i < 200) ? 1 : 3));
            overflow  = $urandom_range(0, 1);
            sum       = 4'($urandom);
            tick();
            exp_d = (q.size() > 0) ? q[0] : 5'd0;
            checks++;
            if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0) || out_data !== exp_d ||
                ovf_count !== 8'(m_ovf)) begin
                errors++;
                $display("FAIL rand[%0d] got cnt=%0d e=%b f=%b ir=%b ov=%b d=%h oc=%0d exp cnt=%0d d=%h oc=%0d",
                         i, count, empty, full, in_ready, out_valid, out_data, ovf_count, q.size(), exp_d, m_ovf);
            end
            checks++;
            if (s_count !== 3'(q.size()) || s_empty !== (q.size() == 0) || s_full !== (q.size() == DEPTH) ||
                s_in_ready !== (q.size() != DEPTH) || s_out_valid !== (q.size() != 0) ||
                s_out_data !== exp_d || s_ovf_count !== 2'(m_ovf2)) begin
                errors++;
                $display("FAIL rand_sat[%0d] got cnt=%0d d=%h oc=%0d exp cnt=%0d d=%h oc=%0d",
                         i, s_count, s_out_data, s_ovf_count, q.size(), exp_d, m_ovf2);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_and_drop();
        test_back_to_back();
        test_ovf_count();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
